ov7670_capture: RTL and testbench
=================================

# ov7670_capture

Capture front end for the OV7670 camera path. The block samples the camera's asynchronous pixel bus (`cam_pclk`, `cam_vsync`, `cam_href`, `cam_data`) on the system clock and pairs bytes into RGB565 pixels. It generates linear frame-buffer addresses and drives a write stream (`we_out`, `wAddr_out`, `wData_out`) that feeds the colour-filter stage directly. Camera is configured for QVGA RGB565 output, high byte first.

## Interface
- `IMG_WIDTH`, 320, pixels per line accepted; extra pixels in a line are dropped.
- `IMG_HEIGHT`, 240, lines per frame accepted; extra lines are dropped.
- `clk`  in  1  system clock; frequency ≥ 4× `cam_pclk`.
- `reset`  in  1  synchronous, active-high reset.
- `capture_en`  in  1  level; enables frame capture.
- `cam_pclk`  in  1  camera pixel clock, asynchronous; sampled as data.
- `cam_vsync`  in  1  camera frame sync; high during vertical blanking.
- `cam_href`  in  1  camera line valid; high during active bytes.
- `cam_data`  in  8  camera byte bus.
- `we_out`  out  1  one-cycle write strobe per captured pixel.
- `wAddr_out`  out  $clog2(IMG_WIDTH*IMG_HEIGHT)  pixel address, y*IMG_WIDTH + x.
- `wData_out`  out  16  RGB565 pixel, {first byte, second byte}.
- `frame_done`  out  1  one-cycle pulse at end of each captured frame.

## Operation
- **Synchronisers:** all camera inputs pass through a 2-flop synchroniser. A third flop on `cam_pclk` supports edge detection. `pclk_rise` = stage2 & ~stage3. `href`, `vsync` and `data` are used from stage2, aligned with `pclk_rise`. A `vsync` rising edge is detected the same way from stage2/stage3.
- **FSM states:** IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, ACTIVE.
  - IDLE: go to WAIT_VS_HIGH when `capture_en`=1.
  - WAIT_VS_HIGH: go to WAIT_VS_LOW when synced vsync=1. This discards any frame already in progress.
  - WAIT_VS_LOW: go to ACTIVE when synced vsync=0; clear x, y, line_base and the byte phase.
  - ACTIVE: capture pixels. On a vsync rising edge, pulse `frame_done` and clear the counters. Then go to WAIT_VS_LOW if `capture_en`=1, otherwise IDLE.
  - Deasserting `capture_en` mid-frame has no effect until the frame ends.
- **Byte pairing (ACTIVE only):**
  - On `pclk_rise` with href=1 and phase=0: latch data into hi_byte; phase←1.
  - On `pclk_rise` with href=1 and phase=1: form pixel {hi_byte, data}; phase←0.
  - If x<IMG_WIDTH and y<IMG_HEIGHT: drive `we_out`=1, `wAddr_out`=line_base+x, `wData_out`=pixel.
  - x increments per pixel and saturates at IMG_WIDTH; saturated pixels are dropped.
- **Line end:** on synced href falling while ACTIVE:
  - Applies only if x>0: y increments (saturating at IMG_HEIGHT), line_base += IMG_WIDTH, x←0.
  - phase←0 in all cases. An odd trailing byte is discarded.
- **Address arithmetic:** uses the running line_base, with no multiplier. line_base is never incremented past (IMG_HEIGHT-1)*IMG_WIDTH.
- **Out-of-range lines:** lines with y ≥ IMG_HEIGHT produce no writes.
- **Outside ACTIVE:** `we_out` is 0.

## Timing
- **Reset:** `we_out`=0, `wAddr_out`=0, `wData_out`=0, `frame_done`=0, FSM=IDLE, all counters and synchronisers 0. Reset asserted mid-frame aborts the frame with no further writes. After release, capture restarts from WAIT_VS_HIGH.
- **Pixel latency:** a camera edge sampled into stage1 at clk edge k gives `pclk_rise` after edge k+1. For a second byte, `we_out`/`wAddr_out`/`wData_out` are registered at edge k+2 and are valid for exactly one cycle.
- **Output hold:** `wAddr_out` and `wData_out` hold their last values while `we_out`=0.
- **Frame end:** `frame_done` is registered at the edge after the vsync rising edge is detected and lasts exactly one cycle.
- **Simultaneous events:** if the vsync rise and a pixel completion occur in the same cycle, the pixel is written first; `frame_done` coincides with or follows that write, never precedes it.
- **Throughput:** one pixel per two `cam_pclk` periods. Correctness requires each `cam_pclk` phase to last ≥ 2 clk cycles.

## Test plan
- **Small frame:** IMG_WIDTH=4, IMG_HEIGHT=2, `capture_en`=1, `clk`=4×`pclk`. Stimulus: vsync high→low, then 2 lines of 8 bytes 0x00..0x0F. Required: 8 writes at addresses 0..7 with data 0x0001, 0x0203, …, 0x0E0F; one `frame_done` after the vsync rise.
- **Mid-frame start:** assert `capture_en` while vsync=0 and href is toggling. Required: no writes until the next full vsync high→low cycle, then addresses start at 0.
- **Overflow:** IMG_WIDTH=4, IMG_HEIGHT=2; drive 3 lines of 12 bytes. Required: exactly 8 writes, addresses 0–7, the 5th/6th pixels of each line dropped, no write for line 3.
- **Odd byte:** a line of 7 bytes. Required: 3 writes; phase cleared, so the next line's first pixel pairs bytes 0 and 1 of that line.
- **Reset mid-frame:** reset asserted after 3 pixels. Required: all outputs 0 the cycle after the reset edge and no writes for the rest of that frame. The next frame restarts at address 0.
- **Capture disable:** drop `capture_en` mid-frame. Required: the current frame completes with `frame_done`, then the FSM goes to IDLE and no writes occur on the following frame.

Source files
------------

// File: rtl/ov7670_capture.sv
// ov7670_capture
//   Capture front end for an OV7670 camera running QVGA RGB565, high byte first.
//   The camera bus is asynchronous to clk: every camera signal is brought in
//   through a 2-flop synchroniser, and pclk/vsync/href get a third flop for
//   edge detection. Byte pairs are assembled into 16-bit pixels and written
//   out as a linear frame-buffer stream.
//
// Ports
//   clk          system clock, at least 4x cam_pclk
//   reset        synchronous, active-high
//   capture_en   level enable; only takes effect at frame boundaries
//   cam_pclk     camera pixel clock (sampled as data)
//   cam_vsync    high during vertical blanking
//   cam_href     high during active bytes of a line
//   cam_data     camera byte bus
//   we_out       one-cycle write strobe per captured pixel
//   wAddr_out    y*IMG_WIDTH + x, held while we_out is low
//   wData_out    {first byte, second byte}, held while we_out is low
//   frame_done   one-cycle pulse when a captured frame ends
module ov7670_capture #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        capture_en,
    input  logic                                        cam_pclk,
    input  logic                                        cam_vsync,
    input  logic                                        cam_href,
    input  logic [7:0]                                  cam_data,
    output logic                                        we_out,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]     wAddr_out,
    output logic [15:0]                                 wData_out,
    output logic                                        frame_done
);

    localparam int AW = $clog2(IMG_WIDTH*IMG_HEIGHT);
    localparam int XW = $clog2(IMG_WIDTH+1);   // must hold IMG_WIDTH (saturation value)
    localparam int YW = $clog2(IMG_HEIGHT+1);

    localparam logic [XW-1:0] X_LIM   = XW'(IMG_WIDTH);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_LIM   = YW'(IMG_HEIGHT);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);
    localparam logic [AW-1:0] LB_MAX  = AW'((IMG_HEIGHT-1)*IMG_WIDTH);
    localparam logic [AW-1:0] LB_STEP = AW'(IMG_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS_HIGH,
        WAIT_VS_LOW,
        ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
    logic       vs_s1_q,   vs_s2_q,   vs_s3_q;
    logic       href_s1_q, href_s2_q, href_s3_q;
    logic [7:0] data_s1_q, data_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_s1_q <= 1'b0; pclk_s2_q <= 1'b0; pclk_s3_q <= 1'b0;
            vs_s1_q   <= 1'b0; vs_s2_q   <= 1'b0; vs_s3_q   <= 1'b0;
            href_s1_q <= 1'b0; href_s2_q <= 1'b0; href_s3_q <= 1'b0;
            data_s1_q <= 8'h00; data_s2_q <= 8'h00;
        end else begin
            pclk_s1_q <= cam_pclk;  pclk_s2_q <= pclk_s1_q; pclk_s3_q <= pclk_s2_q;
            vs_s1_q   <= cam_vsync; vs_s2_q   <= vs_s1_q;   vs_s3_q   <= vs_s2_q;
            href_s1_q <= cam_href;  href_s2_q <= href_s1_q; href_s3_q <= href_s2_q;
            data_s1_q <= cam_data;  data_s2_q <= data_s1_q;
        end
    end

    // href/vsync/data are taken from stage 2 so they line up with pclk_rise.
    logic pclk_rise, vs_rise, href_fall;
    assign pclk_rise = pclk_s2_q & ~pclk_s3_q;
    assign vs_rise   = vs_s2_q   & ~vs_s3_q;
    assign href_fall = ~href_s2_q & href_s3_q;

    // ------------------------------------------------------------------
    // Capture state
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [AW-1:0]   lb_q, lb_d;          // running y*IMG_WIDTH, avoids a multiplier
    logic            phase_q, phase_d;    // 1 = high byte latched, waiting for low byte
    logic [7:0]      hi_q, hi_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic            done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            lb_q    <= '0;
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lb_q    <= lb_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lb_d    = lb_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture_en) state_d = WAIT_VS_HIGH;
            end

            // Waiting for vsync high throws away whatever frame is in flight.
            WAIT_VS_HIGH: begin
                if (vs_s2_q) state_d = WAIT_VS_LOW;
            end

            WAIT_VS_LOW: begin
                if (!vs_s2_q) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    lb_d    = '0;
                    phase_d = 1'b0;
                end
            end

            ACTIVE: begin
                // href is high here and low on a falling edge, so pairing
                // and line end never fire in the same cycle.
                if (pclk_rise && href_s2_q) begin
                    if (!phase_q) begin
                        hi_d    = data_s2_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q < X_LIM) begin
                            if (y_q < Y_LIM) begin
                                we_d   = 1'b1;
                                addr_d = lb_q + AW'(x_q);
                                data_d = {hi_q, data_s2_q};
                            end
                            x_d = x_q + X_ONE;
                        end
                    end
                end

                // An odd trailing byte is dropped by clearing phase; empty
                // lines (x==0) do not advance y.
                if (href_fall) begin
                    phase_d = 1'b0;
                    if (x_q != '0) begin
                        x_d = '0;
                        if (y_q < Y_LIM)   y_d  = y_q + Y_ONE;
                        if (lb_q < LB_MAX) lb_d = lb_q + LB_STEP;
                    end
                end

                // A pixel completing in this cycle is still written (we_d
                // above), so frame_done never precedes the last write.
                if (vs_rise) begin
                    done_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    lb_d    = '0;
                    phase_d = 1'b0;
                    state_d = capture_en ? WAIT_VS_LOW : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign we_out     = we_q;
    assign wAddr_out  = addr_q;
    assign wData_out  = data_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture with a 4x2 image. A table of frame scenarios
// drives the camera bus; each expected write is queued as its byte pair is
// driven and popped when the DUT strobes we_out. Per-frame write and
// frame_done counts are compared against the table.
module tb_ov7670_capture;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = $clog2(W*H);

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_en;
    logic          cam_pclk;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          we_out;
    logic [AW-1:0] wAddr_out;
    logic [15:0]   wData_out;
    logic          frame_done;

    ov7670_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .we_out     (we_out),
        .wAddr_out  (wAddr_out),
        .wData_out  (wData_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;   // posedges at 5,15,...; negedges at 10,20,...

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } exp_t;

    typedef struct {
        string name;
        int    lines;
        int    bpl;        // bytes per line
        bit    en0;        // capture_en at frame start
        int    chg_line;   // after this line, capture_en <= chg_val (-1: never)
        bit    chg_val;
        bit    cap;        // frame expected to be captured
        int    exp_wr;
        int    exp_done;
    } vec_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor / scoreboard
    // ------------------------------------------------------------------
    logic          rst_at_edge = 1'b1;
    logic          done_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic [15:0]   data_prev = '0;

    always @(posedge clk) rst_at_edge <= reset;

    always @(negedge clk) begin
        if (we_out === 1'b1) begin
            wr_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_write", {16'h0, 13'h0, wAddr_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("waddr", 32'(wAddr_out), 32'(e.a));
                chk("wdata", 32'(wData_out), 32'(e.d));
            end
        end else if (!rst_at_edge) begin
            chk("hold_addr", 32'(wAddr_out), 32'(addr_prev));
            chk("hold_data", 32'(wData_out), 32'(data_prev));
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            chk("done_after_writes", 32'(q.size()), 32'd0);
            chk("done_one_cycle", 32'(done_prev), 32'd0);
        end
        done_prev = frame_done;
        addr_prev = wAddr_out;
        data_prev = wData_out;
    end

    // ------------------------------------------------------------------
    // Camera driver: one pclk period = 4 clk, each phase 2 clk
    // ------------------------------------------------------------------
    task automatic put_byte(input logic [7:0] b, input logic h);
        cam_data = b;
        cam_href = h;
        cam_pclk = 1'b0;
        #20;
        cam_pclk = 1'b1;
        #20;
    endtask

    task automatic run_frame(input vec_t v, input int rst_pix);
        int   wr0, d0, pix;
        bit   cap;
        logic [7:0] b, hi;
        exp_t e;
        cap = v.cap;
        wr0 = wr_cnt;
        d0  = done_cnt;
        pix = 0;
        hi  = 8'h00;
        capture_en = v.en0;
        cam_vsync = 1'b1;
        repeat (3) put_byte(8'h00, 1'b0);
        cam_vsync = 1'b0;
        repeat (3) put_byte(8'h00, 1'b0);
        for (int l = 0; l < v.lines; l++) begin
            for (int i = 0; i < v.bpl; i++) begin
                b = 8'(l*v.bpl + i);
                if (i % 2 == 0) begin
                    hi = b;
                end else if (cap && l < H && i/2 < W) begin
                    e.a = AW'(l*W + i/2);
                    e.d = {hi, b};
                    q.push_back(e);
                end
                put_byte(b, 1'b1);
                if (i % 2 == 1) begin
                    pix++;
                    if (pix == rst_pix) begin
                        repeat (4) @(negedge clk);
                        chk({v.name, "_pre_reset_drain"}, 32'(q.size()), 32'd0);
                        reset = 1'b1;
                        @(negedge clk);
                        chk({v.name, "_rst_we"},    32'(we_out),     32'd0);
                        chk({v.name, "_rst_addr"},  32'(wAddr_out),  32'd0);
                        chk({v.name, "_rst_data"},  32'(wData_out),  32'd0);
                        chk({v.name, "_rst_done"},  32'(frame_done), 32'd0);
                        reset = 1'b0;
                        cap = 1'b0;
                    end
                end
            end
            repeat (3) put_byte(8'h00, 1'b0);
            if (l == v.chg_line) capture_en = v.chg_val;
        end
        cam_vsync = 1'b1;
        repeat (3) put_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        chk({v.name, "_writes"},  32'(wr_cnt - wr0),   32'(v.exp_wr));
        chk({v.name, "_done"},    32'(done_cnt - d0),  32'(v.exp_done));
        chk({v.name, "_drained"}, 32'(q.size()),       32'd0);
        q.delete();
    endtask

    vec_t tbl[8];

    initial begin
        //            name         lines bpl en0 chg  val cap wr done
        tbl[0] = '{"small",        2,   8,  1,  -1,  1,  1,  8, 1};
        tbl[1] = '{"overflow",     3,   12, 1,  -1,  1,  1,  8, 1};
        tbl[2] = '{"odd_byte",     2,   7,  1,  -1,  1,  1,  6, 1};
        tbl[3] = '{"one_line",     1,   8,  1,  -1,  1,  1,  4, 1};
        tbl[4] = '{"disable_mid",  2,   8,  1,  0,   0,  1,  8, 1};
        tbl[5] = '{"idle_frame",   2,   8,  0,  -1,  0,  0,  0, 0};
        tbl[6] = '{"mid_start",    2,   8,  0,  0,   1,  0,  0, 0};
        tbl[7] = '{"restart",      2,   8,  1,  -1,  1,  1,  8, 1};

        reset      = 1'b1;
        capture_en = 1'b0;
        cam_pclk   = 1'b0;
        cam_vsync  = 1'b0;
        cam_href   = 1'b0;
        cam_data   = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_we",   32'(we_out),     32'd0);
        chk("reset_addr", 32'(wAddr_out),  32'd0);
        chk("reset_data", 32'(wData_out),  32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_frame(tbl[k], 0);

        // Reset after the third pixel: the frame is abandoned, the three
        // pixels already written stand, and no frame_done follows.
        begin
            vec_t v;
            v = '{"reset_mid", 2, 8, 1, -1, 1, 1, 3, 0};
            run_frame(v, 3);
            v = '{"after_reset", 2, 8, 1, -1, 1, 1, 8, 1};
            run_frame(v, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
